// File: rtl/pipe_mon_pkg.sv
// Shared types and the counter-increment helper for the pipeline trace monitor.
package pipe_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mon_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regWrite;
        logic [31:0] data;
    } trace_rec_t;

    // Increment a w-bit counter held in the low bits of v; sat holds it at all-ones instead of wrapping.
    function automatic logic [63:0] cnt_inc(input logic [63:0] v, input int unsigned w, input bit sat);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (sat && ((v & mask) == mask))
            return mask;
        return (v + 64'd1) & mask;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace records; pushes into a full FIFO are dropped
// unless a pop frees the slot on the same edge.
module trace_fifo
    import pipe_mon_pkg::*;
#(
    parameter type T     = trace_rec_t,
    parameter int  DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  T                           push_rec,
    input  logic                       pop_req,
    output logic                       valid,
    output T                           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, do_pop, do_push;

    assign full    = (count == FULL_LVL);
    assign valid   = (count != '0);
    assign do_pop  = pop_req && valid;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign level   = count;
    // Head is forced to zero while empty so stale storage never shows on the port.
    assign head    = valid ? mem[rd_ptr] : T'('0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= push_rec;
    end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Run-controlled performance counters and retired-instruction trace capture
// for the 5-stage core, sampling the WB and hazard signals every cycle.
module pipe_trace_monitor
    import pipe_mon_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int SAT_MODE    = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           clear,
    input  logic [CNT_W-1:0]               retire_limit,
    input  logic                           wb_isValid,
    input  logic [XLEN-1:0]                wb_pc,
    input  logic [REG_AW-1:0]              wb_rd,
    input  logic                           wb_regWrite,
    input  logic [XLEN-1:0]                wb_data,
    input  logic                           id_stall,
    input  logic                           flush,
    output logic [1:0]                     state_out,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [CNT_W-1:0]               retire_cnt,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               flush_cnt,
    output logic [CNT_W-1:0]               drop_cnt,
    output logic                           overflow,
    output logic                           tr_valid,
    input  logic                           tr_ready,
    output logic [XLEN-1:0]                tr_pc,
    output logic [REG_AW-1:0]              tr_rd,
    output logic [XLEN-1:0]                tr_data,
    output logic                           tr_regWrite,
    output logic [$clog2(TRACE_DEPTH):0]   tr_level
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic              regWrite;
        logic [XLEN-1:0]   data;
    } rec_t;

    mon_state_t        state_q, state_d;
    rec_t              wb_rec, head;
    logic              run, push, drop, limit_hit;
    logic [CNT_W-1:0]  retire_nxt;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return CNT_W'(cnt_inc(64'(v), unsigned'(CNT_W), SAT_MODE != 0));
    endfunction

    assign run        = (state_q == RUN) && !clear;
    assign push       = run && wb_isValid;
    assign retire_nxt = bump(retire_cnt);
    // Auto-stop fires on the edge whose retirement makes the count reach the limit.
    assign limit_hit  = (retire_limit != '0) && wb_isValid && (retire_nxt == retire_limit);
    assign wb_rec     = '{pc: wb_pc, rd: wb_rd, regWrite: wb_regWrite, data: wb_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (stop || limit_hit) state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clear)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (run) begin
                cycle_cnt <= bump(cycle_cnt);
                if (id_stall)
                    stall_cnt <= bump(stall_cnt);
                if (flush)
                    flush_cnt <= bump(flush_cnt);
                if (wb_isValid)
                    retire_cnt <= retire_nxt;
            end
            if (drop) begin
                drop_cnt <= bump(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .T     (rec_t),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .push     (push),
        .push_rec (wb_rec),
        .pop_req  (tr_ready),
        .valid    (tr_valid),
        .head     (head),
        .level    (tr_level),
        .drop     (drop)
    );

    assign state_out   = state_q;
    assign tr_pc       = head.pc;
    assign tr_rd       = head.rd;
    assign tr_regWrite = head.regWrite;
    assign tr_data     = head.data;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Bench for pipe_trace_monitor: three configurations share one stimulus stream and
// are compared each cycle against a queue-based behavioural model.
module tb_pipe_trace_monitor;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [31:0] retire_limit = '0;
    logic        wb_isValid = 1'b0, wb_regWrite = 1'b0, id_stall = 1'b0, flush = 1'b0, tr_ready = 1'b0;
    logic [31:0] wb_pc = '0, wb_data = '0;
    logic [4:0]  wb_rd = '0;

    always #5 clk = ~clk;

    // Instance a: defaults.  b: depth 4, 4-bit saturating.  c: depth 4, 4-bit wrapping.
    logic [1:0]  a_st, b_st, c_st;
    logic [31:0] a_cyc, a_ret, a_stl, a_fls, a_drp, a_pc, a_data, b_pc, b_data, c_pc, c_data;
    logic [3:0]  b_cyc, b_ret, b_stl, b_fls, b_drp, c_cyc, c_ret, c_stl, c_fls, c_drp;
    logic [4:0]  a_rd, b_rd, c_rd, a_lvl;
    logic [2:0]  b_lvl, c_lvl;
    logic        a_ovf, b_ovf, c_ovf, a_vld, b_vld, c_vld, a_rw, b_rw, c_rw;

    pipe_trace_monitor #(.XLEN(32), .REG_AW(5), .CNT_W(32), .TRACE_DEPTH(16), .SAT_MODE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .retire_limit(retire_limit), .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_data(wb_data), .id_stall(id_stall), .flush(flush),
        .state_out(a_st), .cycle_cnt(a_cyc), .retire_cnt(a_ret), .stall_cnt(a_stl),
        .flush_cnt(a_fls), .drop_cnt(a_drp), .overflow(a_ovf), .tr_valid(a_vld),
        .tr_ready(tr_ready), .tr_pc(a_pc), .tr_rd(a_rd), .tr_data(a_data),
        .tr_regWrite(a_rw), .tr_level(a_lvl));

    pipe_trace_monitor #(.XLEN(32), .REG_AW(5), .CNT_W(4), .TRACE_DEPTH(4), .SAT_MODE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .retire_limit(retire_limit[3:0]), .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_data(wb_data), .id_stall(id_stall), .flush(flush),
        .state_out(b_st), .cycle_cnt(b_cyc), .retire_cnt(b_ret), .stall_cnt(b_stl),
        .flush_cnt(b_fls), .drop_cnt(b_drp), .overflow(b_ovf), .tr_valid(b_vld),
        .tr_ready(tr_ready), .tr_pc(b_pc), .tr_rd(b_rd), .tr_data(b_data),
        .tr_regWrite(b_rw), .tr_level(b_lvl));

    pipe_trace_monitor #(.XLEN(32), .REG_AW(5), .CNT_W(4), .TRACE_DEPTH(4), .SAT_MODE(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .retire_limit(retire_limit[3:0]), .wb_isValid(wb_isValid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_data(wb_data), .id_stall(id_stall), .flush(flush),
        .state_out(c_st), .cycle_cnt(c_cyc), .retire_cnt(c_ret), .stall_cnt(c_stl),
        .flush_cnt(c_fls), .drop_cnt(c_drp), .overflow(c_ovf), .tr_valid(c_vld),
        .tr_ready(tr_ready), .tr_pc(c_pc), .tr_rd(c_rd), .tr_data(c_data),
        .tr_regWrite(c_rw), .tr_level(c_lvl));

    // Reference model: state as 0/1/2, counters as plain integers, the FIFO as a queue.
    int     m_st [3];
    longint m_cyc [3], m_ret [3], m_stl [3], m_fls [3], m_drp [3];
    bit     m_ovf [3];
    rec_t   mq [3][$];
    int     dep [3] = '{16, 4, 4};
    longint mx  [3] = '{longint'(32'hFFFF_FFFF), 15, 15};
    bit     sat [3] = '{1'b1, 1'b1, 1'b0};
    int     total = 0, bad = 0;

    function automatic longint inc(input longint v, input longint m, input bit s);
        if (v >= m) return s ? m : 0;
        return v + 1;
    endfunction

    task automatic zero_one(input int i);
        m_st[i] = 0; m_cyc[i] = 0; m_ret[i] = 0; m_stl[i] = 0;
        m_fls[i] = 0; m_drp[i] = 0; m_ovf[i] = 1'b0;
        mq[i].delete();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) zero_one(i);
    endtask

    task automatic model_step();
        bit     do_pop, do_push;
        longint lim;
        rec_t   r;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                zero_one(i);
                continue;
            end
            do_pop  = (mq[i].size() > 0) && tr_ready;
            do_push = 1'b0;
            lim     = longint'(retire_limit) & mx[i];
            r       = '{pc: wb_pc, rd: wb_rd, rw: wb_regWrite, data: wb_data};
            if (m_st[i] == 1) begin
                m_cyc[i] = inc(m_cyc[i], mx[i], sat[i]);
                if (id_stall) m_stl[i] = inc(m_stl[i], mx[i], sat[i]);
                if (flush)    m_fls[i] = inc(m_fls[i], mx[i], sat[i]);
                if (wb_isValid) begin
                    m_ret[i] = inc(m_ret[i], mx[i], sat[i]);
                    if (mq[i].size() < dep[i] || do_pop) do_push = 1'b1;
                    else begin
                        m_drp[i] = inc(m_drp[i], mx[i], sat[i]);
                        m_ovf[i] = 1'b1;
                    end
                end
                if (stop) m_st[i] = 2;
                else if (lim != 0 && wb_isValid && m_ret[i] == lim) m_st[i] = 2;
            end else if (m_st[i] == 0 && start) begin
                m_st[i] = 1;
            end
            if (do_pop)  void'(mq[i].pop_front());
            if (do_push) mq[i].push_back(r);
        end
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input int i, input logic [1:0] st, input logic [31:0] cyc,
                            input logic [31:0] ret, input logic [31:0] stl, input logic [31:0] fls,
                            input logic [31:0] drp, input logic ovf, input logic vld,
                            input logic [31:0] lvl, input rec_t head);
        rec_t e;
        e = (mq[i].size() > 0) ? mq[i][0] : '0;
        chk($sformatf("i%0d.state", i),    80'(st),  80'(m_st[i]));
        chk($sformatf("i%0d.cycle", i),    80'(cyc), 80'(m_cyc[i]));
        chk($sformatf("i%0d.retire", i),   80'(ret), 80'(m_ret[i]));
        chk($sformatf("i%0d.stall", i),    80'(stl), 80'(m_stl[i]));
        chk($sformatf("i%0d.flush", i),    80'(fls), 80'(m_fls[i]));
        chk($sformatf("i%0d.drop", i),     80'(drp), 80'(m_drp[i]));
        chk($sformatf("i%0d.overflow", i), 80'(ovf), 80'(m_ovf[i]));
        chk($sformatf("i%0d.tr_valid", i), 80'(vld), 80'(mq[i].size() > 0));
        chk($sformatf("i%0d.tr_level", i), 80'(lvl), 80'(mq[i].size()));
        chk($sformatf("i%0d.head", i),     80'(head), 80'(e));
    endtask

    task automatic chk_all();
        chk_inst(0, a_st, a_cyc, a_ret, a_stl, a_fls, a_drp, a_ovf, a_vld, 32'(a_lvl),
                 {a_pc, a_rd, a_rw, a_data});
        chk_inst(1, b_st, 32'(b_cyc), 32'(b_ret), 32'(b_stl), 32'(b_fls), 32'(b_drp), b_ovf, b_vld,
                 32'(b_lvl), {b_pc, b_rd, b_rw, b_data});
        chk_inst(2, c_st, 32'(c_cyc), 32'(c_ret), 32'(c_stl), 32'(c_fls), 32'(c_drp), c_ovf, c_vld,
                 32'(c_lvl), {c_pc, c_rd, c_rw, c_data});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic retire(input logic [31:0] pc);
        wb_isValid = 1'b1; wb_pc = pc; wb_rd = 5'($urandom);
        wb_regWrite = 1'($urandom); wb_data = $urandom;
        tick();
        wb_isValid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        // Reset state
        model_reset();
        #12;
        chk_all();
        reset_n = 1'b1;
        tick();

        // Ten retirements at pc 0..36 then stop; drain in order
        pulse_start();
        for (int k = 0; k < 10; k++) begin
            id_stall = 1'($urandom); flush = 1'($urandom);
            retire(32'(k * 4));
        end
        id_stall = 1'b0; flush = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t1.retire", 80'(a_ret), 80'd10);
        chk("t1.cycle", 80'(a_cyc), 80'd11);
        chk("t1.state", 80'(a_st), 80'd2);
        tr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("t1.pop_pc", 80'(a_pc), 80'(k * 4));
            tick();
        end
        chk("t1.level_end", 80'(a_lvl), 80'd0);
        tr_ready = 1'b0;

        // Auto-stop at retire_limit=3
        pulse_clear();
        retire_limit = 32'd3;
        pulse_start();
        for (int k = 0; k < 6; k++) retire(32'h100 + 32'(k * 4));
        chk("t2.state", 80'(a_st), 80'd2);
        chk("t2.retire", 80'(a_ret), 80'd3);
        chk("t2.level", 80'(a_lvl), 80'd3);
        retire_limit = '0;

        // Overflow on the depth-4 instances, then push+pop while full
        pulse_clear();
        pulse_start();
        for (int k = 0; k < 6; k++) retire(32'h200 + 32'(k * 4));
        chk("t3.level", 80'(b_lvl), 80'd4);
        chk("t3.drop", 80'(b_drp), 80'd2);
        chk("t3.overflow", 80'(b_ovf), 80'd1);
        chk("t3.head", 80'(b_pc), 80'h200);
        tr_ready = 1'b1;
        retire(32'h300);
        tr_ready = 1'b0;
        chk("t3.level_pp", 80'(b_lvl), 80'd4);
        chk("t3.drop_pp", 80'(b_drp), 80'd2);
        chk("t3.head_pp", 80'(b_pc), 80'h204);
        stop = 1'b1; tick(); stop = 1'b0;
        tr_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        tr_ready = 1'b0;

        // 20 RUN cycles: saturate vs wrap at 4 bits
        pulse_clear();
        pulse_start();
        for (int k = 0; k < 20; k++) tick();
        chk("t4.sat", 80'(b_cyc), 80'd15);
        chk("t4.wrap", 80'(c_cyc), 80'd4);
        stop = 1'b1; tick(); stop = 1'b0;

        // Clear while DONE
        pulse_clear();
        chk("t5.state", 80'(a_st), 80'd0);
        chk("t5.cycle", 80'(a_cyc), 80'd0);

        // Asynchronous reset mid-run with two records queued
        pulse_start();
        retire(32'h400);
        retire(32'h404);
        chk("t6.pre_level", 80'(a_lvl), 80'd2);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        chk("t6.valid", 80'(a_vld), 80'd0);
        #2 reset_n = 1'b1;
        tick();

        // Randomized run control and traffic
        for (int k = 0; k < 400; k++) begin
            start      = ($urandom % 6) == 0;
            stop       = ($urandom % 20) == 0;
            clear      = ($urandom % 50) == 0;
            if (($urandom % 40) == 0) retire_limit = $urandom % 10;
            wb_isValid = 1'($urandom);
            wb_pc = $urandom; wb_rd = 5'($urandom); wb_regWrite = 1'($urandom); wb_data = $urandom;
            id_stall   = 1'($urandom);
            flush      = 1'($urandom);
            tr_ready   = ($urandom % 3) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
